// File: rtl/cond_unit_pipe.sv
// cond_unit_pipe
// Single-stage ARM-style condition unit with NCTX independent flag contexts.
// An accepted instruction is evaluated against the stored flags of its own
// context; the registered results appear exactly one cycle later. A passing
// instruction may update that context's flags, and the new flags are usable
// by an instruction accepted in the very next cycle. An annulled instruction
// bumps a saturating per-context counter.
//
// Ports
//   CLK, Reset          clock (rising edge), asynchronous active-high reset
//   Valid, Ctx          instruction present, flag context it belongs to
//   Cond, ALUFlags      condition field, {N,Z,C,V} produced by instruction
//   FlagW               [1] write N,Z  [0] write C,V (only if condition passes)
//   PCS, RegW, MemW     unconditioned control requests
//   Stall, Flush        hold everything / kill the stage (Flush wins)
//   RdCtx, CntClr       status read select, clear of the selected counter
//   OutValid..MemWrite  registered results
//   FlagsOut,AnnulCount combinational status read of context RdCtx
//   CtxErr              sticky: an instruction named a non-existent context
module cond_unit_pipe #(
  parameter int NCTX = 2,
  parameter int CNTW = 8
) (
  input  logic                                 CLK,
  input  logic                                 Reset,
  input  logic                                 Valid,
  input  logic [((NCTX > 1) ? $clog2(NCTX) : 1)-1:0] Ctx,
  input  logic [3:0]                           Cond,
  input  logic [3:0]                           ALUFlags,
  input  logic [1:0]                           FlagW,
  input  logic                                 PCS,
  input  logic                                 RegW,
  input  logic                                 MemW,
  input  logic                                 Stall,
  input  logic                                 Flush,
  input  logic [((NCTX > 1) ? $clog2(NCTX) : 1)-1:0] RdCtx,
  input  logic                                 CntClr,
  output logic                                 OutValid,
  output logic                                 CondEx,
  output logic                                 PCSrc,
  output logic                                 RegWrite,
  output logic                                 MemWrite,
  output logic [3:0]                           FlagsOut,
  output logic [CNTW-1:0]                      AnnulCount,
  output logic                                 CtxErr
);

  localparam int CTXW = (NCTX > 1) ? $clog2(NCTX) : 1;
  localparam logic [CTXW:0]   NCTX_V  = (CTXW + 1)'(NCTX);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  // ARM condition decode on a {N,Z,C,V} flag nibble.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic r;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = c;
      4'b0011: r = ~c;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = c & ~z;
      4'b1001: r = ~c | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [3:0]      flags_r [NCTX];
  logic [CNTW-1:0] cnt_r   [NCTX];

  logic            ctx_ok_s;
  logic            rd_ok_s;
  logic            advance_s;   // stage is not frozen by a plain stall
  logic            accept_s;
  logic            pass_s;
  logic [3:0]      cur_flags_s;
  logic [NCTX-1:0] ctx_sel_s;
  logic [NCTX-1:0] clr_sel_s;

  // Acceptance, context selection and condition evaluation.
  always_comb begin
    ctx_ok_s    = ({1'b0, Ctx} < NCTX_V);
    rd_ok_s     = ({1'b0, RdCtx} < NCTX_V);
    advance_s   = ~Stall | Flush;
    accept_s    = Valid & ~Stall & ~Flush & ctx_ok_s;
    cur_flags_s = 4'b0000;
    if (ctx_ok_s) begin
      cur_flags_s = flags_r[Ctx];
    end else begin
      cur_flags_s = 4'b0000;
    end
    pass_s = cond_pass(Cond, cur_flags_s);
    for (int i = 0; i < NCTX; i++) begin
      ctx_sel_s[i] = (Ctx == CTXW'(i));
      clr_sel_s[i] = CntClr & rd_ok_s & advance_s & (RdCtx == CTXW'(i));
    end
  end

  // Per-context flags and saturating annul counters; a clear beats an increment.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NCTX; i++) begin
        flags_r[i] <= 4'b0000;
        cnt_r[i]   <= {CNTW{1'b0}};
      end
    end else begin
      for (int i = 0; i < NCTX; i++) begin
        if (accept_s && pass_s && ctx_sel_s[i]) begin
          if (FlagW[1]) flags_r[i][3:2] <= ALUFlags[3:2];
          if (FlagW[0]) flags_r[i][1:0] <= ALUFlags[1:0];
        end
        if (clr_sel_s[i]) begin
          cnt_r[i] <= {CNTW{1'b0}};
        end else if (accept_s && !pass_s && ctx_sel_s[i] && (cnt_r[i] != CNT_MAX)) begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Registered results: Flush kills, Stall holds, otherwise load or bubble.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      OutValid <= 1'b0;
      CondEx   <= 1'b0;
      PCSrc    <= 1'b0;
      RegWrite <= 1'b0;
      MemWrite <= 1'b0;
    end else if (Flush) begin
      OutValid <= 1'b0;
      CondEx   <= 1'b0;
      PCSrc    <= 1'b0;
      RegWrite <= 1'b0;
      MemWrite <= 1'b0;
    end else if (Stall) begin
      OutValid <= OutValid;
      CondEx   <= CondEx;
      PCSrc    <= PCSrc;
      RegWrite <= RegWrite;
      MemWrite <= MemWrite;
    end else if (accept_s) begin
      OutValid <= 1'b1;
      CondEx   <= pass_s;
      PCSrc    <= pass_s & PCS;
      RegWrite <= pass_s & RegW;
      MemWrite <= pass_s & MemW;
    end else begin
      OutValid <= 1'b0;
      CondEx   <= 1'b0;
      PCSrc    <= 1'b0;
      RegWrite <= 1'b0;
      MemWrite <= 1'b0;
    end
  end

  // Sticky error for an instruction that names a context that does not exist.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      CtxErr <= 1'b0;
    end else if (Valid && !Stall && !Flush && !ctx_ok_s) begin
      CtxErr <= 1'b1;
    end else begin
      CtxErr <= CtxErr;
    end
  end

  // Status read port; out-of-range selects read as zero.
  always_comb begin
    FlagsOut   = 4'b0000;
    AnnulCount = {CNTW{1'b0}};
    if (rd_ok_s) begin
      FlagsOut   = flags_r[RdCtx];
      AnnulCount = cnt_r[RdCtx];
    end else begin
      FlagsOut   = 4'b0000;
      AnnulCount = {CNTW{1'b0}};
    end
  end

endmodule

// File: tb/tb_cond_unit_pipe.sv
// Self-checking bench for cond_unit_pipe (NCTX=3, CNTW=2): directed scenarios
// with hand-computed expectations, then randomized traffic compared each
// cycle against a behavioural model of the condition unit.
module tb_cond_unit_pipe;

  localparam int NCTX = 3;
  localparam int CNTW = 2;
  localparam int CMAX = 3;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       Valid;
  logic [1:0] Ctx;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW;
  logic       Stall, Flush;
  logic [1:0] RdCtx;
  logic       CntClr;
  logic       OutValid, CondEx, PCSrc, RegWrite, MemWrite;
  logic [3:0] FlagsOut;
  logic [1:0] AnnulCount;
  logic       CtxErr;

  cond_unit_pipe #(.NCTX(NCTX), .CNTW(CNTW)) dut (
    .CLK(CLK), .Reset(Reset), .Valid(Valid), .Ctx(Ctx), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .Stall(Stall), .Flush(Flush), .RdCtx(RdCtx), .CntClr(CntClr),
    .OutValid(OutValid), .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .FlagsOut(FlagsOut), .AnnulCount(AnnulCount),
    .CtxErr(CtxErr)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  bit [3:0] m_flags [4];
  int       m_cnt   [4];
  bit       e_ov, e_ce, e_pc, e_rw, e_mw, e_err;

  // Odd condition codes are the negation of the even code below them.
  function automatic bit m_pass(bit [3:0] cond, bit [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return cond[0] ? !base : base;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_flags[i] = 4'b0000;
      m_cnt[i]   = 0;
    end
    e_ov = 1'b0; e_ce = 1'b0; e_pc = 1'b0; e_rw = 1'b0; e_mw = 1'b0; e_err = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit r;
    if (Flush) begin
      e_ov = 1'b0; e_ce = 1'b0; e_pc = 1'b0; e_rw = 1'b0; e_mw = 1'b0;
    end else if (!Stall) begin
      if (Valid && int'(Ctx) < NCTX) begin
        r = m_pass(Cond, m_flags[Ctx]);
        e_ov = 1'b1; e_ce = r; e_pc = r && PCS; e_rw = r && RegW; e_mw = r && MemW;
        if (r) begin
          if (FlagW[1]) m_flags[Ctx][3:2] = ALUFlags[3:2];
          if (FlagW[0]) m_flags[Ctx][1:0] = ALUFlags[1:0];
        end else begin
          m_cnt[Ctx] = (m_cnt[Ctx] < CMAX) ? m_cnt[Ctx] + 1 : CMAX;
        end
      end else begin
        e_ov = 1'b0; e_ce = 1'b0; e_pc = 1'b0; e_rw = 1'b0; e_mw = 1'b0;
        if (Valid) e_err = 1'b1;
      end
    end
    if ((Flush || !Stall) && CntClr && int'(RdCtx) < NCTX) m_cnt[RdCtx] = 0;
  endtask

  task automatic compare();
    chk("OutValid", 32'(OutValid), 32'(e_ov));
    chk("CondEx",   32'(CondEx),   32'(e_ce));
    chk("PCSrc",    32'(PCSrc),    32'(e_pc));
    chk("RegWrite", 32'(RegWrite), 32'(e_rw));
    chk("MemWrite", 32'(MemWrite), 32'(e_mw));
    chk("CtxErr",   32'(CtxErr),   32'(e_err));
    chk("FlagsOut", 32'(FlagsOut), (int'(RdCtx) < NCTX) ? 32'(m_flags[RdCtx]) : 32'd0);
    chk("AnnulCount", 32'(AnnulCount), (int'(RdCtx) < NCTX) ? 32'(m_cnt[RdCtx]) : 32'd0);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    model_step();
    compare();
  endtask

  task automatic set_in(bit v, bit [1:0] c, bit [3:0] cd, bit [3:0] alu, bit [1:0] fw,
                        bit p, bit rw, bit mw, bit st, bit fl, bit [1:0] rd, bit clr);
    Valid = v; Ctx = c; Cond = cd; ALUFlags = alu; FlagW = fw;
    PCS = p; RegW = rw; MemW = mw; Stall = st; Flush = fl; RdCtx = rd; CntClr = clr;
  endtask

  // Assert reset between edges, confirm everything clears at once, release on negedge.
  task automatic reset_pulse();
    Reset = 1'b1;
    #1;
    chk("rst_OutValid", 32'(OutValid), 32'd0);
    chk("rst_CondEx",   32'(CondEx),   32'd0);
    chk("rst_PCSrc",    32'(PCSrc),    32'd0);
    chk("rst_RegWrite", 32'(RegWrite), 32'd0);
    chk("rst_MemWrite", 32'(MemWrite), 32'd0);
    chk("rst_CtxErr",   32'(CtxErr),   32'd0);
    chk("rst_FlagsOut", 32'(FlagsOut), 32'd0);
    chk("rst_AnnulCount", 32'(AnnulCount), 32'd0);
    model_reset();
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    set_in(1'b0, 2'd0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    #2;
    reset_pulse();

    // Cond=AL on ctx0 writes Z
    set_in(1'b1, 2'd0, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    step();
    chk("req033_ov", 32'(OutValid), 32'd1);
    chk("req033_ce", 32'(CondEx), 32'd1);
    chk("req033_flags", 32'(FlagsOut), 32'h4);

    // EQ on ctx0 sees the Z written one cycle earlier
    set_in(1'b1, 2'd0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    step();
    chk("req034_ce0", 32'(CondEx), 32'd1);
    // EQ on ctx1 (flags still clear) is annulled
    set_in(1'b1, 2'd1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    step();
    chk("req034_ce1", 32'(CondEx), 32'd0);
    chk("req034_cnt1", 32'(AnnulCount), 32'd1);

    // NV with all requests and flag writes: nothing leaks through
    set_in(1'b1, 2'd1, 4'b1111, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0);
    step();
    chk("req035_pc", 32'(PCSrc), 32'd0);
    chk("req035_rw", 32'(RegWrite), 32'd0);
    chk("req035_mw", 32'(MemWrite), 32'd0);
    chk("req035_flags", 32'(FlagsOut), 32'h0);
    chk("req035_cnt", 32'(AnnulCount), 32'd2);

    // Stall holds twice, then Flush with Stall clears outputs
    set_in(1'b1, 2'd0, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    step();
    set_in(1'b1, 2'd0, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("req036_hold_ov", 32'(OutValid), 32'd1);
      chk("req036_hold_pc", 32'(PCSrc), 32'd1);
      chk("req036_hold_rw", 32'(RegWrite), 32'd1);
      chk("req036_hold_flags", 32'(FlagsOut), 32'h4);
    end
    set_in(1'b1, 2'd0, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    step();
    chk("req036_flush_ov", 32'(OutValid), 32'd0);
    chk("req036_flush_pc", 32'(PCSrc), 32'd0);
    chk("req036_flush_rw", 32'(RegWrite), 32'd0);
    chk("req036_flush_flags", 32'(FlagsOut), 32'h4);

    // ctx1 counter saturates at 3, then clear beats a simultaneous annul
    set_in(1'b1, 2'd1, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("req037_sat", 32'(AnnulCount), 32'd3);
    set_in(1'b1, 2'd1, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
    step();
    chk("req037_clr", 32'(AnnulCount), 32'd0);

    // Out-of-range context: bubble and sticky error, then reset mid-stream
    set_in(1'b1, 2'd3, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0);
    step();
    chk("req038_ov", 32'(OutValid), 32'd0);
    chk("req038_err", 32'(CtxErr), 32'd1);
    chk("req038_rd_oor", 32'(FlagsOut), 32'h0);
    set_in(1'b0, 2'd0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    step();
    chk("req038_err_sticky", 32'(CtxErr), 32'd1);
    set_in(1'b1, 2'd0, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    step();
    reset_pulse();

    // Randomized traffic against the model
    for (int k = 0; k < 2000; k++) begin
      set_in($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 4'($urandom),
             4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
             2'($urandom_range(0, 3)), $urandom_range(0, 11) == 0);
      step();
      if ($urandom_range(0, 249) == 0) reset_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
